// File: rtl/multicpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: states, opcodes,
// funct codes, ALU control codes and datapath select codes.
package multicpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_EXEC_I = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_OR    = 2'd2,
    ALU_OP_FUNCT = 2'd3
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1100;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;
  localparam logic [1:0] SRCA_B  = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps an ALU operation class and the R-type funct field to the ALU control
// code, and flags funct values the datapath does not implement.
module alu_decoder
  import multicpu_pkg::*;
(
  input  logic [5:0] funct,
  input  alu_op_t    alu_op,
  output logic [3:0] alu_control,
  output logic       funct_legal
);

  logic [3:0] funct_control;

  always_comb begin
    funct_control = ALU_ADD;
    funct_legal   = 1'b1;
    case (funct)
      FN_ADD:  funct_control = ALU_ADD;
      FN_SUB:  funct_control = ALU_SUB;
      FN_AND:  funct_control = ALU_AND;
      FN_OR:   funct_control = ALU_OR;
      FN_SLT:  funct_control = ALU_SLT;
      FN_SLL:  funct_control = ALU_SLL;
      default: funct_legal   = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD:   alu_control = ALU_ADD;
      ALU_OP_SUB:   alu_control = ALU_SUB;
      ALU_OP_OR:    alu_control = ALU_OR;
      ALU_OP_FUNCT: alu_control = funct_control;
      default:      alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects and write enables.
//
// state  | meaning
// FETCH  | read instruction at PC into IR, PC <- PC + 4
// DECODE | dispatch on Op, precompute branch target into ALUOut
// MEMADR | compute load/store address A + Imm
// MEMRD  | read data memory at ALUOut
// MEMWB  | write MDR into rt
// MEMWR  | write B to data memory at ALUOut
// EXEC_R | R-type ALU operation
// ALUWB  | write ALUOut into rd (R-type) or rt (I-type)
// BRANCH | compare A and B, conditionally load PC from ALUOut
// EXEC_I | addi / ori ALU operation
// JUMP   | load PC with jump target
module multi_cycle_control
  import multicpu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       ZF,
  output logic       PCEn,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ExtOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state, state_next;
  alu_op_t    alu_op;
  logic       alu_active;
  logic [3:0] dec_control;
  logic       funct_legal;

  alu_decoder u_alu_decoder (
    .funct       (Funct),
    .alu_op      (alu_op),
    .alu_control (dec_control),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  assign State      = state;
  assign ALUControl = alu_active ? dec_control : ALU_AND;

  always_comb begin
    state_next = S_FETCH;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ExtOp      = 1'b1;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    Illegal    = 1'b0;
    alu_op     = ALU_OP_ADD;
    alu_active = 1'b0;

    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCEn       = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        alu_active = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM_SH;
        alu_active = 1'b1;
        case (Op)
          OP_LW, OP_SW:    state_next = S_MEMADR;
          OP_BEQ, OP_BNE:  state_next = S_BRANCH;
          OP_ADDI, OP_ORI: state_next = S_EXEC_I;
          OP_J:            state_next = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal) state_next = S_EXEC_R;
            else             Illegal    = 1'b1;
          end
          default:         Illegal    = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_active = 1'b1;
        state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        alu_op     = ALU_OP_FUNCT;
        alu_active = 1'b1;
        state_next = S_ALUWB;
        // sll shifts rt (B) by shamt, which sits in Imm[10:6]
        if (Funct == FN_SLL) begin
          ALUSrcA = SRCA_B;
          ALUSrcB = SRCB_IMM;
        end else begin
          ALUSrcA = SRCA_A;
          ALUSrcB = SRCB_B;
        end
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (Op == OP_RTYPE);
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        alu_op     = ALU_OP_SUB;
        alu_active = 1'b1;
        PCSrc      = PCSRC_ALUOUT;
        PCEn       = (Op == OP_BNE) ? ~ZF : ZF;
      end
      S_EXEC_I: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_active = 1'b1;
        state_next = S_ALUWB;
        if (Op == OP_ORI) begin
          alu_op = ALU_OP_OR;
          ExtOp  = 1'b0;
        end
      end
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        PCEn  = 1'b1;
      end
      default: Illegal = 1'b1;
    endcase

    if (Reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed, table-driven bench for the multi-cycle control FSM: one table row
// per clock cycle, plus hand-written cycles-per-instruction sequences.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b000000;
  logic       zf = 1'b0;
  logic       pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, ext_op;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_control, state;
  logic       illegal;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .CLK        (clk),
    .Reset      (reset),
    .Op         (op),
    .Funct      (funct),
    .ZF         (zf),
    .PCEn       (pc_en),
    .IorD       (iord),
    .IRWrite    (ir_write),
    .MemWrite   (mem_write),
    .RegWrite   (reg_write),
    .RegDst     (reg_dst),
    .MemtoReg   (mem_to_reg),
    .ExtOp      (ext_op),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ALUControl (alu_control),
    .PCSrc      (pc_src),
    .Illegal    (illegal),
    .State      (state)
  );

  // {PCEn,IorD,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg,ExtOp,SrcA,SrcB,ALUControl,PCSrc,Illegal}
  localparam logic [18:0] O_RST     = 19'b0_0_0_0_0_0_0_1_00_01_0010_00_0;
  localparam logic [18:0] O_FETCH   = 19'b1_0_1_0_0_0_0_1_00_01_0010_00_0;
  localparam logic [18:0] O_DEC     = 19'b0_0_0_0_0_0_0_1_00_11_0010_00_0;
  localparam logic [18:0] O_DEC_ILL = 19'b0_0_0_0_0_0_0_1_00_11_0010_00_1;
  localparam logic [18:0] O_MADR    = 19'b0_0_0_0_0_0_0_1_01_10_0010_00_0;
  localparam logic [18:0] O_MRD     = 19'b0_1_0_0_0_0_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_MWB     = 19'b0_0_0_0_1_0_1_1_00_00_0000_00_0;
  localparam logic [18:0] O_MWR     = 19'b0_1_0_1_0_0_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_MWR_RST = 19'b0_1_0_0_0_0_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_X_SLL   = 19'b0_0_0_0_0_0_0_1_10_10_1100_00_0;
  localparam logic [18:0] O_X_SLT   = 19'b0_0_0_0_0_0_0_1_01_00_0111_00_0;
  localparam logic [18:0] O_X_SUB   = 19'b0_0_0_0_0_0_0_1_01_00_0110_00_0;
  localparam logic [18:0] O_WB_R    = 19'b0_0_0_0_1_1_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_WB_I    = 19'b0_0_0_0_1_0_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_WB_RST  = 19'b0_0_0_0_0_0_0_1_00_00_0000_00_0;
  localparam logic [18:0] O_BR_T    = 19'b1_0_0_0_0_0_0_1_01_00_0110_01_0;
  localparam logic [18:0] O_BR_N    = 19'b0_0_0_0_0_0_0_1_01_00_0110_01_0;
  localparam logic [18:0] O_X_ORI   = 19'b0_0_0_0_0_0_0_0_01_10_0001_00_0;
  localparam logic [18:0] O_X_ADDI  = 19'b0_0_0_0_0_0_0_1_01_10_0010_00_0;
  localparam logic [18:0] O_JUMP    = 19'b1_0_0_0_0_0_0_1_00_00_0000_10_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010, RT = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zf;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void add(logic r, logic [5:0] o, logic [5:0] f, logic z,
                              logic [3:0] s, logic [18:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zf = z; v.st = s; v.out = e;
    vecs.push_back(v);
  endfunction

  // FETCH sees a junk opcode, which must be ignored; DECODE sees the real one
  function automatic void fetch_decode(logic [5:0] o, logic [5:0] f, logic [18:0] dec_out);
    add(1'b0, BAD, 6'b111111, 1'b0, 4'd0, O_FETCH);
    add(1'b0, o, f, 1'b0, 4'd1, dec_out);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  int cyc, ill_cnt;
  logic wr_seen;

  initial begin
    add(1'b1, LW, 6'd0, 1'b0, 4'd0, O_RST);
    add(1'b1, LW, 6'd0, 1'b0, 4'd0, O_RST);
    add(1'b1, LW, 6'd0, 1'b0, 4'd0, O_RST);
    // lw right after reset
    add(1'b0, LW, 6'd0, 1'b0, 4'd0, O_FETCH);
    add(1'b0, LW, 6'd0, 1'b0, 4'd1, O_DEC);
    add(1'b0, LW, 6'd0, 1'b0, 4'd2, O_MADR);
    add(1'b0, LW, 6'd0, 1'b0, 4'd3, O_MRD);
    add(1'b0, LW, 6'd0, 1'b0, 4'd4, O_MWB);
    // sll, slt, sub
    fetch_decode(RT, 6'b000000, O_DEC);
    add(1'b0, RT, 6'b000000, 1'b0, 4'd6, O_X_SLL);
    add(1'b0, RT, 6'b000000, 1'b0, 4'd7, O_WB_R);
    fetch_decode(RT, 6'b101010, O_DEC);
    add(1'b0, RT, 6'b101010, 1'b0, 4'd6, O_X_SLT);
    add(1'b0, RT, 6'b101010, 1'b0, 4'd7, O_WB_R);
    fetch_decode(RT, 6'b100010, O_DEC);
    add(1'b0, RT, 6'b100010, 1'b0, 4'd6, O_X_SUB);
    add(1'b0, RT, 6'b100010, 1'b0, 4'd7, O_WB_R);
    // branches: beq taken/not, bne not/taken
    fetch_decode(BEQ, 6'd0, O_DEC);
    add(1'b0, BEQ, 6'd0, 1'b1, 4'd8, O_BR_T);
    fetch_decode(BEQ, 6'd0, O_DEC);
    add(1'b0, BEQ, 6'd0, 1'b0, 4'd8, O_BR_N);
    fetch_decode(BNE, 6'd0, O_DEC);
    add(1'b0, BNE, 6'd0, 1'b1, 4'd8, O_BR_N);
    fetch_decode(BNE, 6'd0, O_DEC);
    add(1'b0, BNE, 6'd0, 1'b0, 4'd8, O_BR_T);
    // ori, addi, j
    fetch_decode(ORI, 6'd0, O_DEC);
    add(1'b0, ORI, 6'd0, 1'b0, 4'd9, O_X_ORI);
    add(1'b0, ORI, 6'd0, 1'b0, 4'd7, O_WB_I);
    fetch_decode(ADDI, 6'd0, O_DEC);
    add(1'b0, ADDI, 6'd0, 1'b0, 4'd9, O_X_ADDI);
    add(1'b0, ADDI, 6'd0, 1'b0, 4'd7, O_WB_I);
    fetch_decode(JMP, 6'd0, O_DEC);
    add(1'b0, JMP, 6'd0, 1'b0, 4'd10, O_JUMP);
    // illegal opcode, illegal funct
    fetch_decode(BAD, 6'd0, O_DEC_ILL);
    fetch_decode(RT, 6'b001000, O_DEC_ILL);
    // sw, then sw abandoned by reset in MEMWR
    fetch_decode(SW, 6'd0, O_DEC);
    add(1'b0, SW, 6'd0, 1'b0, 4'd2, O_MADR);
    add(1'b0, SW, 6'd0, 1'b0, 4'd5, O_MWR);
    fetch_decode(SW, 6'd0, O_DEC);
    add(1'b0, SW, 6'd0, 1'b0, 4'd2, O_MADR);
    add(1'b1, SW, 6'd0, 1'b0, 4'd5, O_MWR_RST);
    // addi abandoned by reset in ALUWB
    fetch_decode(ADDI, 6'd0, O_DEC);
    add(1'b0, ADDI, 6'd0, 1'b0, 4'd9, O_X_ADDI);
    add(1'b1, ADDI, 6'd0, 1'b0, 4'd7, O_WB_RST);
    add(1'b0, LW, 6'd0, 1'b0, 4'd0, O_FETCH);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      op    = vecs[i].op;
      funct = vecs[i].funct;
      zf    = vecs[i].zf;
      #1;
      check($sformatf("row%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("row%0d_outputs", i),
            {13'd0, pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
             ext_op, alu_src_a, alu_src_b, alu_control, pc_src, illegal},
            {13'd0, vecs[i].out});
    end

    // lw instruction length, measured from the current FETCH
    op = LW; funct = 6'd0; zf = 1'b0; reset = 1'b0;
    cyc = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (state == 4'd0) break;
      cyc++;
    end
    check("lw_cycles", cyc, 5);

    // illegal opcode: two cycles, one-cycle Illegal pulse, no writes
    op = BAD;
    cyc = 1; ill_cnt = 0; wr_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      ill_cnt += int'(illegal);
      if (state == 4'd0) break;
      wr_seen = wr_seen | mem_write | reg_write;
      cyc++;
    end
    check("illegal_cycles", cyc, 2);
    check("illegal_pulse", ill_cnt, 1);
    check("illegal_no_write", {31'd0, wr_seen}, 32'd0);

    // bne not taken: three cycles, PC never loaded in BRANCH
    op = BNE; zf = 1'b1;
    cyc = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (state == 4'd0) break;
      if (state == 4'd8) check("bne_hold_pcen", {31'd0, pc_en}, 32'd0);
      cyc++;
    end
    check("bne_cycles", cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control finite state machine (FSM) for the multi-cycle CPU. It sits directly upstream of the ALU. It decodes the latched instruction's `Op`/`Funct` fields and drives the ALU operand selects and `ALUControl` each cycle. It consumes the ALU's `ZF` equality flag for branches and sequences the PC, IR, register-file and memory write enables across fetch/decode/execute/memory/writeback steps. It holds no datapath registers; it is a Moore FSM, except for `PCEn`.

## Interface
Parameters: none; all encodings come from the shared package.
- `CLK`  in  1  single clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `Op`  in  6  instruction [31:26] from IR
- `Funct`  in  6  instruction [5:0] from IR
- `ZF`  in  1  ALU equality flag (Src1 == Src2)
- `PCEn`  out  1  PC load enable
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  IR load enable
- `MemWrite`  out  1  data memory write
- `RegWrite`  out  1  register file write
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd
- `MemtoReg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `ExtOp`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- `ALUSrcA`  out  2  Src1 select: 00 = PC, 01 = A, 10 = B
- `ALUSrcB`  out  2  Src2 select: 00 = B, 01 = 4, 10 = Imm, 11 = Imm<<2
- `ALUControl`  out  4  ALU operation code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1100
- `PCSrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `Illegal`  out  1  one-cycle pulse when an unsupported instruction is decoded
- `State`  out  4  current state, for debug

## Operation
Supported instructions:
- R-type (`Op`=000000), selected by `Funct`: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000.
- I-type and jump: lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010.

Outputs not listed for a state are 0, except `ExtOp`, which defaults to 1. States and their outputs:
- FETCH (0): `IorD`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=01, ADD, `PCSrc`=00, `PCEn`=1.
  - Next: DECODE.
- DECODE (1): `ALUSrcA`=00, `ALUSrcB`=11, ADD. This precomputes the branch target into ALUOut.
  - Next by `Op`: lw/sw → MEMADR; R-type → EXEC_R; beq/bne → BRANCH; addi/ori → EXEC_I; j → JUMP.
  - Any other `Op`, or an R-type with an unlisted `Funct`: → FETCH with `Illegal`=1. No architectural write occurs.
- MEMADR (2): `ALUSrcA`=01, `ALUSrcB`=10, ADD.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD (3): `IorD`=1. Next: MEMWB.
- MEMWB (4): `RegWrite`=1, `RegDst`=0, `MemtoReg`=1. Next: FETCH.
- MEMWR (5): `IorD`=1, `MemWrite`=1. Next: FETCH.
- EXEC_R (6): `ALUSrcA`=01, `ALUSrcB`=00, `ALUControl` from `Funct`.
  - sll instead uses `ALUSrcA`=10 and `ALUSrcB`=10 with `ExtOp`=1, so the shift amount (shamt) reaches Src2[10:6].
  - Next: ALUWB.
- ALUWB (7): `RegWrite`=1, `MemtoReg`=0.
  - `RegDst`=1 when entered from EXEC_R, 0 when entered from EXEC_I. The FSM tracks this through `Op`, which is stable because `IRWrite`=0.
  - Next: FETCH.
- BRANCH (8): `ALUSrcA`=01, `ALUSrcB`=00, SUB, `PCSrc`=01.
  - `PCEn` = `ZF` for beq, `~ZF` for bne. This is the only combinational dependency on an input.
  - Next: FETCH.
- EXEC_I (9): `ALUSrcA`=01, `ALUSrcB`=10.
  - addi: ADD with `ExtOp`=1. ori: OR with `ExtOp`=0.
  - Next: ALUWB.
- JUMP (10): `PCSrc`=10, `PCEn`=1. Next: FETCH.
- Encodings 11–15 are unreachable. If entered, the next state is FETCH, all enables are 0 and `Illegal`=1.

## Timing
- Every state lasts exactly one cycle. There are no wait states and no memory handshake; memory is single-cycle.
- Cycles per instruction: lw 5; sw, R-type, addi, ori 4; beq, bne, j 3; illegal 2.
- Reset:
  - While `Reset`=1, `PCEn`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0 combinationally and `Illegal`=0.
  - At the first rising edge with `Reset`=1, `State` ← FETCH (0).
  - The first cycle after `Reset` deasserts is a normal FETCH.
- Reset asserted mid-instruction (for example in MEMWR or ALUWB) suppresses that cycle's writes. The instruction is abandoned.
- `Op`/`Funct` are sampled only in DECODE and in states after DECODE. Their value during FETCH is ignored.
- `ZF` is sampled only in BRANCH, in the same cycle as the PC update.

## Structure
- Shared package `multicpu_pkg` holds:
  - the state encoding (4-bit, values above);
  - opcode and funct constants;
  - `ALUControl` codes;
  - `ALUSrcA`/`ALUSrcB`/`PCSrc` select codes.
- One sub-module, `alu_decoder`, is combinational and maps (`Funct`, ALU operation class) → `ALUControl`.
  - Operation classes: ADD, SUB, OR, FUNCT.
  - It also produces the `FunctLegal` flag used by DECODE.
- The top level holds the state register, the next-state logic and the output decode.

## Test plan
- Reset held 3 cycles, then released, then the lw opcode supplied → `State` sequence 0,1,2,3,4,0. `RegWrite`=1 only in state 4, with `MemtoReg`=1 and `RegDst`=0.
- R-type with `Funct`=000000 (sll) → in EXEC_R, `ALUControl`=1100, `ALUSrcA`=10, `ALUSrcB`=10. Then ALUWB with `RegDst`=1.
- beq with `ZF`=1 → `PCEn`=1 in BRANCH. Repeat with `ZF`=0 → `PCEn`=0. For bne the results invert. Instruction length is 3 cycles in every case.
- ori (001101) → EXEC_I with `ALUControl`=0001 and `ExtOp`=0. Then ALUWB with `RegDst`=0.
- Op 111111, and separately R-type `Funct`=001000 → DECODE→FETCH, `Illegal`=1 for one cycle, and no write enable asserted in either case.
- `Reset` asserted during MEMWR of sw → `MemWrite`=0 in that cycle and `State`=0 on the next cycle.
